// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width,
// and the bit-counter width helper.
package serial_sub_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A single-bit operand still needs a one-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/fsub1.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module fsub1 (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor, LSB first, one bit per clock through a single
// registered borrow; the result is published only once all bits are done.
import serial_sub_pkg::*;

module serial_sub4 #(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, res_reg, full_res;
   logic [CW-1:0]    cnt_reg;
   logic             borrow_reg;
   logic [WIDTH-1:0] diff_reg;
   logic             bout_reg;
   logic             d_bit, borrow_bit;
   logic             accept, last_bit;

   fsub1 u_fsub1 (
      .x    (a_reg[cnt_reg]),
      .y    (b_reg[cnt_reg]),
      .bin  (borrow_reg),
      .d    (d_bit),
      .bout (borrow_bit)
   );

   assign accept   = (state_reg != SHIFT) && start;
   assign last_bit = (cnt_reg == LAST);

   // Partial result with the bit being computed this cycle merged in.
   always_comb begin
      full_res          = res_reg;
      full_res[cnt_reg] = d_bit;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: state_next = start ? SHIFT : IDLE;
         SHIFT:      state_next = last_bit ? DONE : SHIFT;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         res_reg    <= '0;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         diff_reg   <= '0;
         bout_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            res_reg    <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
         end else if (state_reg == SHIFT) begin
            res_reg    <= full_res;
            borrow_reg <= borrow_bit;
            cnt_reg    <= cnt_reg + 1'b1;
            // diff/bout only ever change here, so no partial result leaks out.
            if (last_bit) begin
               diff_reg <= full_res;
               bout_reg <= borrow_bit;
            end
         end
      end
   end

   assign diff = diff_reg;
   assign bout = bout_reg;
   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: cycle-level behavioural model plus
// directed scenarios, exhaustive sweep and randomized traffic.
module tb_serial_sub4;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] diff;
   logic         bout, busy, done;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: a countdown of remaining bit-clocks and the pending result.
   int           m_rem = 0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_diff = '0;
   logic         m_bout = 1'b0;
   logic [W:0]   m_pend = '0;

   serial_sub4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .diff  (diff),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update and per-cycle comparison.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_diff = '0; m_bout = 0;
         end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 0;
               m_done = 1;
               {m_bout, m_diff} = m_pend;
            end
         end else begin
            m_done = 0;
            if (start) begin
               m_rem  = W;
               m_busy = 1;
               m_pend = {1'b0, a} - {1'b0, b};
            end
         end
         #1;
         check("model_diff", int'(diff), int'(m_diff));
         check("model_bout", int'(bout), int'(m_bout));
         check("model_busy", int'(busy), int'(m_busy));
         check("model_done", int'(done), int'(m_done));
      end
   end

   task automatic wait_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input int av, input int bv, input int ediff, input int ebout);
      bit ok;
      @(negedge clk);
      start = 1; a = W'(av); b = W'(bv);
      @(negedge clk);
      start = 0;
      wait_done(ok);
      if (ok) begin
         check($sformatf("diff_%0d_%0d", av, bv), int'(diff), ediff);
         check($sformatf("bout_%0d_%0d", av, bv), int'(bout), ebout);
      end
   endtask

   initial begin
      bit ok;
      int busy_cnt;
      int done_cnt;

      repeat (2) @(negedge clk);
      check("rst_diff", int'(diff), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst = 0;

      // 9 - 6: busy for exactly 4 cycles, then 3 with no borrow.
      @(negedge clk);
      start = 1; a = 4'd9; b = 4'd6;
      @(negedge clk);
      start = 0;
      busy_cnt = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      check("busy_cycles", busy_cnt, 4);
      check("diff_9_6", int'(diff), 3);
      check("bout_9_6", int'(bout), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);

      run_op(3, 5, 14, 1);
      run_op(0, 0, 0, 0);
      run_op(15, 0, 15, 0);

      // Request during SHIFT is ignored.
      @(negedge clk);
      start = 1; a = 4'd7; b = 4'd2;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      start = 1; a = 4'd1; b = 4'd9;
      @(negedge clk);
      start = 0;
      wait_done(ok);
      check("ignore_diff", int'(diff), 5);
      check("ignore_bout", int'(bout), 0);

      // Back-to-back start accepted in the DONE cycle.
      start = 1; a = 4'd4; b = 4'd4;
      @(negedge clk);
      start = 0;
      check("b2b_busy", int'(busy), 1);
      busy_cnt = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", busy_cnt, 4);
      check("b2b_diff", int'(diff), 0);
      check("b2b_bout", int'(bout), 0);

      // Reset during the second SHIFT cycle aborts without a done pulse.
      @(negedge clk);
      start = 1; a = 4'd3; b = 4'd5;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_diff", int'(diff), 0);
      check("abort_bout", int'(bout), 0);
      done_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);

      // Exhaustive sweep of all operand pairs.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            int r;
            r = (x - y) & 31;
            run_op(x, y, r & 15, r >> 4);
         end
      end

      // Randomized traffic; the per-cycle model comparison does the checking.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         rst   = ($urandom_range(0, 99) == 0);
      end
      @(negedge clk);
      start = 0; rst = 0;
      repeat (8) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: start  input  1  request pulse; operands captured when accepted.
REQ-005 Port: a  input  WIDTH  minuend.
REQ-006 Port: b  input  WIDTH  subtrahend.
REQ-007 Port: diff  output  WIDTH  registered result, a - b modulo 2^WIDTH.
REQ-008 Port: bout  output  1  registered borrow-out, 1 when a < b unsigned.
REQ-009 Port: busy  output  1  high while a subtraction is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking a new valid diff/bout.

Function
REQ-011 The block SHALL be a bit-serial subtractor, one bit per clock, LSB first, ripple-borrow through a single registered borrow bit.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch a and b, clear the borrow register, clear the bit counter, and enter SHIFT.
REQ-014 In IDLE or DONE with start=0, the FSM SHALL go to (or remain in) IDLE.
REQ-015 In SHIFT, each edge SHALL compute d = a[i] ^ b[i] ^ borrow and borrow' = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow) for bit i = counter, then store d and increment the counter.
REQ-016 When the counter equals WIDTH-1 in SHIFT, the FSM SHALL load diff and bout from the completed result and enter DONE on the same edge.
REQ-017 start SHALL be ignored while in SHIFT; latched operands SHALL NOT change mid-operation.
REQ-018 busy SHALL equal 1 exactly in SHIFT; done SHALL equal 1 exactly in DONE.
REQ-019 Latency: done SHALL be high in the cycle following the edge WIDTH clocks after the accepting edge (4 clocks for WIDTH=4), for exactly one cycle unless back-to-back start re-enters SHIFT.
REQ-020 diff and bout SHALL hold their last result until the next completion; they SHALL NOT show partial results.
REQ-021 start asserted during DONE SHALL be accepted, allowing back-to-back operations at one result per WIDTH+1 cycles.

Reset
REQ-022 rst=1 SHALL force state IDLE, counter 0, borrow 0, diff 0, bout 0, busy 0, done 0 on the next edge.
REQ-023 rst SHALL take priority over start and abort any operation in SHIFT without updating diff/bout.

Structure
REQ-024 State encoding constants, WIDTH default, and counter width ($clog2(WIDTH)) SHALL live in shared package serial_sub_pkg.
REQ-025 The per-bit borrow logic SHALL be one combinational sub-module, fsub1 (inputs x, y, bin; outputs d, bout), instantiated once.
REQ-026 Top-level pin mapping onto the tile I/O SHALL be done in the tile wrapper, not in serial_sub4.

Verification
REQ-027 a=9, b=6, start pulse -> busy 4 cycles, then done=1 with diff=3, bout=0.
REQ-028 a=3, b=5 -> diff=14, bout=1; a=0, b=0 -> diff=0, bout=0; a=15, b=0 -> diff=15, bout=0.
REQ-029 start with a=7, b=2; during SHIFT, drive start=1 with a=1, b=9 -> result diff=5, bout=0; second request ignored.
REQ-030 start during the DONE cycle with a=4, b=4 -> busy immediately next cycle, done 4 cycles later with diff=0, bout=0.
REQ-031 rst=1 in second SHIFT cycle -> next cycle busy=0, done=0, diff=0, bout=0; no done pulse follows.
REQ-032 Exhaustive sweep, all 256 (a, b) pairs for WIDTH=4 -> {bout, diff} equals (a - b) mod 32 in every case.
